scan_decoder: RTL
=================

// Module: scan_decoder
// PURPOSE
//  Registered, parametrised ADDR_WIDTH-to-2^ADDR_WIDTH one-hot decoder with enable; successor to the 2-to-4 gate decoder.
//  Adds two modes: DIRECT (decode addr, 1-cycle latency) and SCAN (self-timed sweep of every output line, then a done pulse).
//  Drives register-file/bank selects and walks every select line during bring-up.
// PARAMETERS
//  ADDR_WIDTH   2  address bits; out width OUTS = 1<<ADDR_WIDTH (localparam)
//  STEP_CYCLES  4  cycles each line is held during SCAN (>=1)
// PORTS
//  clk        in   1           system clock; all state on rising edge
//  reset      in   1           synchronous, active-high reset
//  enable     in   1           global enable; low forces exit to IDLE
//  mode       in   1           0 = DIRECT, 1 = SCAN
//  addr       in   ADDR_WIDTH  line to select in DIRECT
//  start      in   1           SCAN start strobe (sampled in IDLE only)
//  out        out  OUTS        registered one-hot select, or all-zero
//  valid      out  1           registered; 1 iff out != 0
//  scan_idx   out  ADDR_WIDTH  index of line currently driven in SCAN
//  scan_done  out  1           one-cycle pulse after a complete sweep
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high (port reset).
//  Reset: state=IDLE; out=0, valid=0, scan_idx=0, scan_done=0, step timer=0. Reset wins over all inputs, including mid-scan.
//  FSM states: IDLE, DIRECT, SCAN, DONE (one-hot or binary, implementer's choice).
//  IDLE: out=0 (see macro). enable&!mode -> DIRECT, out<=1<<addr on the same edge.
//    enable&mode&start -> SCAN, scan_idx<=0, timer<=0, out<=1 on the same edge. start with mode=0 or enable=0 is ignored.
//  DIRECT: each edge with enable&!mode, out<=1<<addr (latency 1 cycle, addr changes tracked every cycle).
//    enable=0 or mode=1 -> IDLE; out<=0 on that edge. No SCAN starts directly from DIRECT; it must pass through IDLE.
//  SCAN: out=1<<scan_idx. Timer counts 0..STEP_CYCLES-1; at terminal count timer<=0, scan_idx<=scan_idx+1.
//    At terminal count with scan_idx==OUTS-1 -> DONE, out<=0. Each line is high exactly STEP_CYCLES cycles.
//    Total SCAN time is OUTS*STEP_CYCLES cycles. start is ignored while in SCAN; addr and mode are ignored.
//    enable=0 aborts: -> IDLE, out<=0, scan_idx<=0, scan_done stays 0.
//  DONE: exactly one cycle with scan_done=1, out=0, valid=0; then IDLE unconditionally.
//    A held start needs a fresh IDLE cycle, so back-to-back sweeps have one DONE cycle plus >=1 IDLE cycle between them.
//  Invariants: out is always one-hot or zero. valid==|out every cycle.
//    scan_idx wraps only via DONE (never increments past OUTS-1). Timer width is $clog2(STEP_CYCLES+1).
// CONFIGURATION
//  DECODER_HOLD_EN defined: on DIRECT->IDLE because enable fell, out/valid keep the last decoded value while in IDLE,
//    until the next DIRECT/SCAN entry or reset. A mode change or SCAN abort still clears out.
//  DECODER_HOLD_EN undefined: out/valid clear on every exit to IDLE (default).
// TESTING (ADDR_WIDTH=2, STEP_CYCLES=4 unless stated)
//  1 Reset: reset=1 two cycles with enable=1, mode=0, addr=3 -> out=0000, valid=0; after release, next edge out=1000.
//  2 DIRECT sweep: enable=1, mode=0, addr 0,1,2,3 on successive cycles -> out 0001,0010,0100,1000 one cycle later each;
//    enable=0 -> out=0000 next edge.
//  3 SCAN: start pulse -> out 0001 x4, 0010 x4, 0100 x4, 1000 x4, then scan_done=1 for one cycle with out=0000; idle after.
//  4 Abort/reset mid-scan: enable=0 during the 0100 phase -> out=0000, scan_done never asserts;
//    repeat with reset -> all outputs at reset values.
//  5 Ignored inputs: start with mode=0 -> no scan; start and addr toggling during SCAN -> timing unchanged;
//    ADDR_WIDTH=3, STEP_CYCLES=1 -> 8 single-cycle lines, then done.
//  6 Macro: DECODER_HOLD_EN on, DIRECT addr=2 then enable=0 -> out stays 0100, valid=1; macro off -> out=0000.

Source files
------------

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with enable: DIRECT decodes addr, SCAN sweeps every line, then pulses scan_done.
// Optional DECODER_HOLD_EN: keep the last DIRECT value in IDLE after enable drops.
module scan_decoder #(
  parameter int ADDR_WIDTH  = 2,
  parameter int STEP_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         mode,
  input  logic [ADDR_WIDTH-1:0]        addr,
  input  logic                         start,
  output logic [(1<<ADDR_WIDTH)-1:0]   out,
  output logic                         valid,
  output logic [ADDR_WIDTH-1:0]        scan_idx,
  output logic                         scan_done
);

  localparam int OUTS = 1 << ADDR_WIDTH;
  localparam int TW   = $clog2(STEP_CYCLES + 1);

  localparam logic [TW-1:0]         T_LAST = TW'(STEP_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] I_LAST = '1;
  localparam logic [OUTS-1:0]       LINE0  = OUTS'(1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   timer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out       <= '0;
      valid     <= 1'b0;
      scan_idx  <= '0;
      scan_done <= 1'b0;
      timer     <= '0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && !mode) begin
            state <= DIRECT;
            out   <= LINE0 << addr;
            valid <= 1'b1;
          end else if (enable && mode && start) begin
            state    <= SCAN;
            scan_idx <= '0;
            timer    <= '0;
            out      <= LINE0;
            valid    <= 1'b1;
          end else begin
`ifdef DECODER_HOLD_EN
            out   <= out;
            valid <= valid;
`else
            out   <= '0;
            valid <= 1'b0;
`endif
          end
        end
        DIRECT: begin
          if (enable && !mode) begin
            out   <= LINE0 << addr;
            valid <= 1'b1;
          end else begin
            state <= IDLE;
`ifdef DECODER_HOLD_EN
            // Only a falling enable keeps the last select; a mode change clears it.
            if (enable) begin
              out   <= '0;
              valid <= 1'b0;
            end
`else
            out   <= '0;
            valid <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (!enable) begin
            state    <= IDLE;
            out      <= '0;
            valid    <= 1'b0;
            scan_idx <= '0;
            timer    <= '0;
          end else if (timer == T_LAST) begin
            timer <= '0;
            if (scan_idx == I_LAST) begin
              state     <= DONE;
              out       <= '0;
              valid     <= 1'b0;
              scan_idx  <= '0;
              scan_done <= 1'b1;
            end else begin
              scan_idx <= scan_idx + 1'b1;
              out      <= out << 1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          // start is not sampled here, so a held start waits for a fresh IDLE cycle.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
